video_frame_writer: RTL and testbench

//  Downstream of the video scaler: takes its sparse-DE 32-bit pixel stream ({8'b0,R,G,B}), packs 8 pixels per
//  256-bit word, buffers the words in a sync FIFO and issues burst writes to the DDR write port.

---
 rtl/video_pkg.sv | 15 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/video_frame_writer.sv | 186 ++++++++++++++++++
 tb/tb_video_frame_writer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants and FSM state type for the video frame writer.
package video_pkg;

    localparam int PIX_W        = 32;
    localparam int WORD_W       = 256;
    localparam int PIX_PER_WORD = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        DONE
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level, full and empty flags.
module sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == DEPTH_L);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    // A push into a full FIFO is still taken when a pop frees a slot in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointer and level bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/video_frame_writer.sv
// Packs sparse 32-bit pixels into 256-bit words, buffers them and issues
// burst writes into ping-pong frame buffers.
module video_frame_writer
    import video_pkg::*;
#(
    parameter int              ADDR_W     = 28,
    parameter int              BURST_LEN  = 16,
    parameter int              FIFO_DEPTH = 64,
    parameter logic [ADDR_W-1:0] BUF0_BASE = 'h0,
    parameter logic [ADDR_W-1:0] BUF1_BASE = 'h80000
) (
    input  logic              pixclk_in,
    input  logic              rst,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic [31:0]       wr_data_in,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_len,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [255:0]      wr_dout,
    output logic              buf_done,
    output logic              buf_idx,
    output logic              overflow
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] BURST_LVL = LW'(BURST_LEN);

    // Packer state
    logic              vs_q;
    logic              vs_rise;
    logic [2:0]        pack_cnt_q;
    logic [PIX_W-1:0]  pack_q [PIX_PER_WORD-1];
    logic [WORD_W-1:0] word_q;
    logic              push_q;
    logic [WORD_W-1:0] pad_word;

    // FIFO interface
    logic [WORD_W-1:0] fifo_rdata;
    logic [LW-1:0]     fifo_level;
    logic              fifo_full, fifo_empty, fifo_pop;

    // FSM / address generator state
    state_t            state_q;
    logic              wr_req_q, buf_done_q, buf_idx_q, buf_q, flush_pend_q, overflow_q;
    logic [ADDR_W-1:0] wr_addr_q, offset_q, base;
    logic [7:0]        wr_len_q, rem_q;

    assign vs_rise  = vs_in & ~vs_q;
    assign base     = buf_q ? BUF1_BASE : BUF0_BASE;
    assign wr_valid = (state_q == DATA) & ~fifo_empty;
    assign fifo_pop = wr_valid & wr_ready;
    assign wr_dout  = wr_valid ? fifo_rdata : '0;
    assign wr_req   = wr_req_q;
    assign wr_addr  = wr_addr_q;
    assign wr_len   = wr_len_q;
    assign buf_done = buf_done_q;
    assign buf_idx  = buf_idx_q;
    assign overflow = overflow_q;

    // Collect the slots already filled; unfilled slots read as zero (flush padding).
    always_comb begin
        pad_word = '0;
        for (int unsigned i = 0; i < PIX_PER_WORD - 1; i++) begin
            if (3'(i) < pack_cnt_q) pad_word[i*PIX_W +: PIX_W] = pack_q[i];
        end
    end

    // Pixel packer and vsync edge detect; a completed word is pushed the following cycle.
    always_ff @(posedge pixclk_in or posedge rst) begin
        if (rst) begin
            vs_q       <= 1'b0;
            pack_cnt_q <= '0;
            word_q     <= '0;
            push_q     <= 1'b0;
            for (int unsigned i = 0; i < PIX_PER_WORD - 1; i++) pack_q[i] <= '0;
        end else begin
            vs_q   <= vs_in;
            push_q <= 1'b0;
            if (vs_rise) begin
                if (pack_cnt_q != '0) begin
                    word_q     <= pad_word;
                    push_q     <= 1'b1;
                    pack_cnt_q <= '0;
                end
            end else if (de_in && !vs_in) begin
                if (pack_cnt_q == 3'd7) begin
                    word_q     <= {wr_data_in, pad_word[WORD_W-PIX_W-1:0]};
                    push_q     <= 1'b1;
                    pack_cnt_q <= '0;
                end else begin
                    pack_q[pack_cnt_q] <= wr_data_in;
                    pack_cnt_q         <= pack_cnt_q + 3'd1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH(WORD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (pixclk_in),
        .rst_i  (rst),
        .push_i (push_q),
        .wdata_i(word_q),
        .pop_i  (fifo_pop),
        .rdata_o(fifo_rdata),
        .level_o(fifo_level),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // Sticky drop flag; a drop in the same cycle as the vsync edge keeps it set.
    always_ff @(posedge pixclk_in or posedge rst) begin
        if (rst)                                   overflow_q <= 1'b0;
        else if (push_q && fifo_full && !fifo_pop) overflow_q <= 1'b1;
        else if (vs_rise)                          overflow_q <= 1'b0;
    end

    // Burst FSM: request, stream words, advance offset; close the frame once drained.
    // Flush decisions wait for a pending push so the last padded word is never missed.
    always_ff @(posedge pixclk_in or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_len_q     <= '0;
            rem_q        <= '0;
            offset_q     <= '0;
            buf_q        <= 1'b0;
            buf_idx_q    <= 1'b0;
            buf_done_q   <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            buf_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (fifo_level >= BURST_LVL) begin
                        state_q   <= REQ;
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= base + offset_q;
                        wr_len_q  <= 8'(BURST_LEN);
                    end else if (flush_pend_q && !push_q) begin
                        if (!fifo_empty) begin
                            state_q   <= REQ;
                            wr_req_q  <= 1'b1;
                            wr_addr_q <= base + offset_q;
                            wr_len_q  <= 8'(fifo_level);
                        end else begin
                            state_q      <= DONE;
                            buf_done_q   <= 1'b1;
                            buf_idx_q    <= buf_q;
                            buf_q        <= ~buf_q;
                            offset_q     <= '0;
                            flush_pend_q <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (wr_ack) begin
                        wr_req_q <= 1'b0;
                        rem_q    <= wr_len_q;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (fifo_pop) begin
                        rem_q <= rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            offset_q <= offset_q + ADDR_W'({wr_len_q, 5'b0});
                            state_q  <= IDLE;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (vs_rise) flush_pend_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_frame_writer.sv
// Randomized directed bench for video_frame_writer with a frame-level reference model.
module tb_video_frame_writer;

    logic         clk = 1'b0;
    logic         rst, vs, de;
    logic [31:0]  din;
    logic         wr_req, wr_ack, wr_valid, wr_ready, buf_done, buf_idx, overflow;
    logic [27:0]  wr_addr;
    logic [7:0]   wr_len;
    logic [255:0] wr_dout;

    always #5 clk = ~clk;

    video_frame_writer #(
        .ADDR_W    (28),
        .BURST_LEN (16),
        .FIFO_DEPTH(64),
        .BUF0_BASE (28'h0),
        .BUF1_BASE (28'h80000)
    ) dut (
        .pixclk_in (clk),
        .rst       (rst),
        .vs_in     (vs),
        .de_in     (de),
        .wr_data_in(din),
        .wr_req    (wr_req),
        .wr_ack    (wr_ack),
        .wr_addr   (wr_addr),
        .wr_len    (wr_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_dout   (wr_dout),
        .buf_done  (buf_done),
        .buf_idx   (buf_idx),
        .overflow  (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] words_q[$];
    logic [27:0]  ra_q[$];
    logic [7:0]   rl_q[$];
    logic         done_q[$];
    logic [31:0]  pix_q[$];
    logic         exp_buf = 1'b0;
    int           ack_dly = 0;
    int           rdy_mode = 0;
    bit           ack_hold = 1'b0;
    int           ack_cnt = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Sink: decides ready/ack half a cycle ahead of each rising edge and logs
    // every beat, grant and frame-done that the coming edge will complete.
    always @(negedge clk) begin
        if (rst) begin
            wr_ack   = 1'b0;
            wr_ready = 1'b0;
            ack_cnt  = 0;
        end else begin
            case (rdy_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = ~wr_ready;
                default: wr_ready = 1'($urandom_range(1));
            endcase
            if (wr_valid && wr_ready) words_q.push_back(wr_dout);
            wr_ack = 1'b0;
            if (wr_req && !ack_hold) begin
                if (ack_cnt >= ack_dly) begin
                    wr_ack = 1'b1;
                    ra_q.push_back(wr_addr);
                    rl_q.push_back(wr_len);
                    ack_cnt = 0;
                end else begin
                    ack_cnt++;
                end
            end
            if (buf_done) done_q.push_back(buf_idx);
        end
    end

    task automatic send_pixels(input int n, input int dens, input bit seq);
        int i = 0;
        while (i < n) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < dens) begin
                de  = 1'b1;
                din = seq ? 32'(i) : {8'h00, 24'($urandom)};
                pix_q.push_back(din);
                i++;
            end else begin
                de = 1'b0;
            end
        end
        @(negedge clk);
        de  = 1'b0;
        din = '0;
    endtask

    // Raise vsync, wait for the frame to close, then compare everything the
    // sink logged against the words/bursts derived from the pixel list.
    task automatic finish_frame(input int max_words, input bit ovf_test);
        int cnt, nw, nfull, nreq;
        logic [255:0] ew;
        logic [27:0]  bbase;
        @(negedge clk);
        vs = 1'b1;
        if (ovf_test) begin
            repeat (3) @(negedge clk);
            chk("ovf_clear_on_vs", overflow, 0);
            ack_hold = 1'b0;
        end
        cnt = 0;
        while (done_q.size() == 0 && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
        repeat (4) @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);

        nw = (pix_q.size() + 7) / 8;
        if (nw > max_words) nw = max_words;
        chk("word_count", words_q.size(), nw);
        for (int w = 0; w < nw && w < words_q.size(); w++) begin
            ew = '0;
            for (int s = 0; s < 8; s++)
                if (w * 8 + s < pix_q.size()) ew[s*32 +: 32] = pix_q[w*8+s];
            chk("word_data", words_q[w], ew);
        end
        nfull = nw / 16;
        nreq  = nfull + ((nw % 16) != 0 ? 1 : 0);
        bbase = exp_buf ? 28'h80000 : 28'h0;
        chk("req_count", ra_q.size(), nreq);
        for (int r = 0; r < nreq && r < ra_q.size(); r++) begin
            chk("req_addr", ra_q[r], bbase + 28'(r * 512));
            chk("req_len", rl_q[r], (r < nfull) ? 16 : (nw % 16));
        end
        chk("done_count", done_q.size(), 1);
        if (done_q.size() > 0) chk("done_idx", done_q[0], exp_buf);
        exp_buf = ~exp_buf;
        words_q.delete(); ra_q.delete(); rl_q.delete(); done_q.delete(); pix_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] ew;
        int cnt;
        rst = 1'b1; vs = 1'b0; de = 1'b0; din = '0;
        #1;
        chk("rst_wr_req", wr_req, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_len", wr_len, 0);
        chk("rst_wr_dout", wr_dout, 0);
        chk("rst_buf_done", buf_done, 0);
        chk("rst_buf_idx", buf_idx, 0);
        chk("rst_overflow", overflow, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full burst of index-valued pixels, grant after 3 cycles
        ack_dly = 3; rdy_mode = 0;
        send_pixels(128, 100, 1'b1);
        cnt = 0;
        while (words_q.size() == 0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        ew = '0;
        for (int s = 0; s < 8; s++) ew[s*32 +: 32] = 32'(s);
        chk("burst_word0", (words_q.size() > 0) ? words_q[0] : '1, ew);
        chk("burst_overflow", overflow, 0);
        finish_frame(1000, 1'b0);

        // Short flush: 8 words, lands in buffer 1
        ack_dly = 1;
        send_pixels(64, 60, 1'b0);
        finish_frame(1000, 1'b0);

        // Partial word padding, random ready
        rdy_mode = 2;
        send_pixels(13, 80, 1'b0);
        finish_frame(1000, 1'b0);

        // Empty frame still completes and toggles the buffer
        finish_frame(1000, 1'b0);

        // Backpressure: ready alternates, 200 words -> 12 full bursts + one of 8
        rdy_mode = 1; ack_dly = 2;
        send_pixels(1600, 50, 1'b0);
        chk("bp_overflow", overflow, 0);
        finish_frame(1000, 1'b0);

        // Overflow: grant withheld, 75 words offered, only 64 fit
        rdy_mode = 0; ack_dly = 0; ack_hold = 1'b1;
        send_pixels(600, 100, 1'b0);
        chk("ovf_set", overflow, 1);
        finish_frame(64, 1'b1);

        // Reset in the middle of a data burst
        ack_dly = 1;
        send_pixels(128, 100, 1'b0);
        cnt = 0;
        while (words_q.size() < 5 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        chk("mid_burst_reached", words_q.size() >= 5, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_wr_req", wr_req, 0);
        chk("abort_wr_valid", wr_valid, 0);
        chk("abort_wr_dout", wr_dout, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_wr_len", wr_len, 0);
        chk("abort_buf_idx", buf_idx, 0);
        chk("abort_overflow", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        words_q.delete(); ra_q.delete(); rl_q.delete(); done_q.delete(); pix_q.delete();
        exp_buf = 1'b0;
        repeat (2) @(negedge clk);
        send_pixels(40, 70, 1'b0);
        finish_frame(1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
